// File: rtl/spio_hss_mux_pkt_framer_if.sv
// Channel-side and serial-side signal bundle of the multi-channel HSS packet framer.
// The framer attaches through 'slave'; the packet sources and serial control side use 'master'.
interface spio_hss_mux_pkt_framer_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int CHAN_BITS    = 3,
    parameter int PKT_BITS     = 64
);
    logic                             HANDSHAKE_COMPLETE_IN;
    logic [NUM_CHANNELS*PKT_BITS-1:0] TX_PKT_DATA_IN;
    logic [NUM_CHANNELS-1:0]          TX_PKT_VLD_IN;
    logic [NUM_CHANNELS-1:0]          TX_PKT_RDY_OUT;
    logic                             CREDIT_RET_VLD_IN;
    logic [CHAN_BITS-1:0]             CREDIT_RET_CHAN_IN;
    logic [31:0]                      TXDATA_OUT;
    logic [3:0]                       TXCHARISK_OUT;
    logic                             TXRDY_IN;
    logic                             CREDIT_ERR_OUT;
    logic [31:0]                      FRAMES_SENT_OUT;

    modport slave (
        input  HANDSHAKE_COMPLETE_IN,
        input  TX_PKT_DATA_IN,
        input  TX_PKT_VLD_IN,
        output TX_PKT_RDY_OUT,
        input  CREDIT_RET_VLD_IN,
        input  CREDIT_RET_CHAN_IN,
        output TXDATA_OUT,
        output TXCHARISK_OUT,
        input  TXRDY_IN,
        output CREDIT_ERR_OUT,
        output FRAMES_SENT_OUT
    );

    modport master (
        output HANDSHAKE_COMPLETE_IN,
        output TX_PKT_DATA_IN,
        output TX_PKT_VLD_IN,
        input  TX_PKT_RDY_OUT,
        output CREDIT_RET_VLD_IN,
        output CREDIT_RET_CHAN_IN,
        input  TXDATA_OUT,
        input  TXCHARISK_OUT,
        output TXRDY_IN,
        input  CREDIT_ERR_OUT,
        input  FRAMES_SENT_OUT
    );
endinterface

// File: rtl/spio_hss_mux_pkt_framer.sv
// N-channel credit-gated round-robin TX framer: one header word plus PKT_BITS/32 data words
// per packet onto the 32-bit word stream feeding the HSS serial control.
module spio_hss_mux_pkt_framer #(
    parameter int NUM_CHANNELS = 8,
    parameter int CHAN_BITS    = 3,
    parameter int PKT_BITS     = 64,
    parameter int CREDITS      = 8,
    parameter int CREDIT_BITS  = 4
) (
    input  logic                    CLK_IN,
    input  logic                    RESET_IN,
    spio_hss_mux_pkt_framer_if.slave bus
);
    localparam int PKT_WORDS = PKT_BITS / 32;
    localparam int IDX_BITS  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    localparam logic [31:0]            IDLE_WORD   = 32'hBC00_0000;
    localparam logic [3:0]             K_CTRL      = 4'b1000;
    localparam logic [3:0]             K_DATA      = 4'b0000;
    localparam logic [CREDIT_BITS-1:0] CREDIT_FULL = CREDIT_BITS'(CREDITS);
    localparam logic [IDX_BITS-1:0]    IDX_LAST    = IDX_BITS'(PKT_WORDS - 1);
    localparam logic [CHAN_BITS:0]     NCH_WIDE    = (CHAN_BITS + 1)'(NUM_CHANNELS);
    localparam logic [CHAN_BITS-1:0]   CHAN_LAST   = CHAN_BITS'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [CHAN_BITS-1:0]   rr_q, rr_d;
    logic [CREDIT_BITS-1:0] credit_q [NUM_CHANNELS];
    logic [CREDIT_BITS-1:0] credit_d [NUM_CHANNELS];
    logic [PKT_BITS-1:0]    shift_q, shift_d;
    logic [31:0]            txdata_q, txdata_d;
    logic [3:0]             txk_q, txk_d;
    logic                   err_q, err_d;
    logic [31:0]            frames_q, frames_d;

    logic [NUM_CHANNELS-1:0] elig_s;
    logic [NUM_CHANNELS-1:0] grant_s;
    logic [NUM_CHANNELS-1:0] ret_s;
    logic                    grant_vld_s;
    logic [CHAN_BITS-1:0]    grant_chan_s;
    logic [CHAN_BITS:0]      cand_s;
    logic [CHAN_BITS:0]      sum_s;
    logic                    hit_s;

    // Per-channel eligibility and decoded credit return
    always_comb begin
        elig_s = '0;
        ret_s  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            elig_s[c] = bus.TX_PKT_VLD_IN[c] && (credit_q[c] != '0) &&
                        bus.HANDSHAKE_COMPLETE_IN && (state_q == ST_IDLE) && bus.TXRDY_IN;
            ret_s[c]  = bus.CREDIT_RET_VLD_IN && (bus.CREDIT_RET_CHAN_IN == CHAN_BITS'(c));
        end
    end

    // Round-robin search starting at rr_q, first eligible channel wins
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_chan_s = '0;
        grant_s      = '0;
        cand_s       = '0;
        sum_s        = '0;
        hit_s        = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            sum_s        = {1'b0, rr_q} + (CHAN_BITS + 1)'(k);
            cand_s       = (sum_s >= NCH_WIDE) ? (sum_s - NCH_WIDE) : sum_s;
            hit_s        = !grant_vld_s && elig_s[cand_s[CHAN_BITS-1:0]];
            grant_chan_s = hit_s ? cand_s[CHAN_BITS-1:0] : grant_chan_s;
            grant_vld_s  = grant_vld_s || hit_s;
        end
        if (grant_vld_s) begin
            grant_s[grant_chan_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Frame sequencer: header on grant, then data words MSW first; everything holds while TXRDY_IN is low
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        shift_d  = shift_q;
        txdata_d = txdata_q;
        txk_d    = txk_q;
        frames_d = frames_q;
        if (bus.TXRDY_IN) begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        shift_d  = bus.TX_PKT_DATA_IN[int'(grant_chan_s)*PKT_BITS +: PKT_BITS];
                        txdata_d = {8'hFB, 8'h00, 8'(PKT_WORDS), 8'(grant_chan_s)};
                        txk_d    = K_CTRL;
                        idx_d    = '0;
                        state_d  = ST_DATA;
                        rr_d     = (grant_chan_s == CHAN_LAST) ? '0 : grant_chan_s + CHAN_BITS'(1);
                    end else begin
                        txdata_d = IDLE_WORD;
                        txk_d    = K_CTRL;
                    end
                end
                ST_DATA: begin
                    txdata_d = shift_q[PKT_BITS-1 -: 32];
                    txk_d    = K_DATA;
                    shift_d  = shift_q << 32;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        state_d  = ST_IDLE;
                        frames_d = frames_q + 32'd1;
                    end else begin
                        idx_d    = idx_q + IDX_BITS'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    txdata_d = IDLE_WORD;
                    txk_d    = K_CTRL;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Credit bookkeeping: link-down reload, return/grant netting, overflow detection
    always_comb begin
        err_d = err_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            credit_d[c] = credit_q[c];
            err_d = err_d | (ret_s[c] && !grant_s[c] && (credit_q[c] == CREDIT_FULL));
            if (!bus.HANDSHAKE_COMPLETE_IN && (state_q == ST_IDLE)) begin
                credit_d[c] = CREDIT_FULL;
            end else if (ret_s[c] && !grant_s[c]) begin
                credit_d[c] = (credit_q[c] == CREDIT_FULL) ? credit_q[c]
                                                            : credit_q[c] + CREDIT_BITS'(1);
            end else if (grant_s[c] && !ret_s[c]) begin
                credit_d[c] = credit_q[c] - CREDIT_BITS'(1);
            end else begin
                credit_d[c] = credit_q[c];
            end
        end
    end

    // State, datapath and credit registers
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_q     <= '0;
            shift_q  <= '0;
            txdata_q <= IDLE_WORD;
            txk_q    <= K_CTRL;
            err_q    <= 1'b0;
            frames_q <= 32'd0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                credit_q[c] <= CREDIT_FULL;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            shift_q  <= shift_d;
            txdata_q <= txdata_d;
            txk_q    <= txk_d;
            err_q    <= err_d;
            frames_q <= frames_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                credit_q[c] <= credit_d[c];
            end
        end
    end

    assign bus.TX_PKT_RDY_OUT  = grant_s;
    assign bus.TXDATA_OUT      = txdata_q;
    assign bus.TXCHARISK_OUT   = txk_q;
    assign bus.CREDIT_ERR_OUT  = err_q;
    assign bus.FRAMES_SENT_OUT = frames_q;

endmodule

// File: tb/tb_spio_hss_mux_pkt_framer.sv
// Bench for spio_hss_mux_pkt_framer: directed scenarios plus a randomized run against a
// frame-level reference model (word queue per frame, credit array, rotating pointer).
module tb_spio_hss_mux_pkt_framer;
    localparam int NCH  = 8;
    localparam int CB   = 3;
    localparam int PB   = 64;
    localparam int PW   = PB / 32;
    localparam int CRED = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    spio_hss_mux_pkt_framer_if #(.NUM_CHANNELS(NCH), .CHAN_BITS(CB), .PKT_BITS(PB)) bus ();

    spio_hss_mux_pkt_framer #(
        .NUM_CHANNELS(NCH), .CHAN_BITS(CB), .PKT_BITS(PB), .CREDITS(CRED), .CREDIT_BITS(4)
    ) dut (
        .CLK_IN  (clk),
        .RESET_IN(rst_n),
        .bus     (bus)
    );

    // reference model state
    logic [31:0] m_word;
    logic [3:0]  m_k;
    int          m_rr;
    int          m_cred [NCH];
    bit          m_err;
    int          m_frames;
    logic [31:0] m_q [$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.HANDSHAKE_COMPLETE_IN = 1'b1;
        bus.TXRDY_IN              = 1'b1;
        bus.TX_PKT_VLD_IN         = '0;
        bus.TX_PKT_DATA_IN        = '0;
        bus.CREDIT_RET_VLD_IN     = 1'b0;
        bus.CREDIT_RET_CHAN_IN    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int m_grant();
        int c;
        if (m_q.size() != 0 || !bus.HANDSHAKE_COMPLETE_IN || !bus.TXRDY_IN) return -1;
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (bus.TX_PKT_VLD_IN[c] && m_cred[c] > 0) return c;
        end
        return -1;
    endfunction

    task automatic m_step(input int g);
        bit          idle_before;
        bit          r;
        bit          gc;
        logic [PB-1:0] pkt;
        idle_before = (m_q.size() == 0);
        if (bus.TXRDY_IN) begin
            if (!idle_before) begin
                m_word = m_q.pop_front();
                m_k    = 4'b0000;
                if (m_q.size() == 0) m_frames++;
            end else if (g >= 0) begin
                m_word = {8'hFB, 8'h00, 8'(PW), 8'(g)};
                m_k    = 4'b1000;
                pkt    = bus.TX_PKT_DATA_IN[g*PB +: PB];
                for (int w = 0; w < PW; w++) m_q.push_back(pkt[PB-1-32*w -: 32]);
                m_rr   = (g + 1) % NCH;
            end else begin
                m_word = 32'hBC00_0000;
                m_k    = 4'b1000;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            r  = bus.CREDIT_RET_VLD_IN && (int'(bus.CREDIT_RET_CHAN_IN) == c);
            gc = (g == c);
            if (r && !gc && m_cred[c] == CRED) m_err = 1'b1;
            if (!bus.HANDSHAKE_COMPLETE_IN && idle_before) m_cred[c] = CRED;
            else if (r && !gc) m_cred[c] = (m_cred[c] < CRED) ? m_cred[c] + 1 : m_cred[c];
            else if (gc && !r) m_cred[c] = m_cred[c] - 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.HANDSHAKE_COMPLETE_IN = 1'b1;
        bus.TXRDY_IN              = 1'b1;
        bus.TX_PKT_VLD_IN         = '0;
        bus.TX_PKT_DATA_IN        = '0;
        bus.CREDIT_RET_VLD_IN     = 1'b0;
        bus.CREDIT_RET_CHAN_IN    = '0;
        @(negedge clk);
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000) begin errors++; $display("FAIL reset_txdata got=%h exp=bc000000", bus.TXDATA_OUT); end
        checks++; if (bus.TXCHARISK_OUT !== 4'b1000) begin errors++; $display("FAIL reset_k got=%b exp=1000", bus.TXCHARISK_OUT); end
        checks++; if (bus.CREDIT_ERR_OUT !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.CREDIT_ERR_OUT); end
        checks++; if (bus.FRAMES_SENT_OUT !== 32'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", bus.FRAMES_SENT_OUT); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000 || bus.TXCHARISK_OUT !== 4'b1000 || bus.TX_PKT_RDY_OUT !== 8'h00)
                begin errors++; $display("FAIL idle_cycle data=%h k=%b rdy=%h exp bc000000/1000/00", bus.TXDATA_OUT, bus.TXCHARISK_OUT, bus.TX_PKT_RDY_OUT); end
            tick();
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        bus.TX_PKT_DATA_IN[3*PB +: PB] = 64'h1122_3344_5566_7788;
        bus.TX_PKT_VLD_IN = 8'h08;
        #1;
        checks++; if (bus.TX_PKT_RDY_OUT !== 8'h08) begin errors++; $display("FAIL single_rdy got=%h exp=08", bus.TX_PKT_RDY_OUT); end
        tick();
        bus.TX_PKT_VLD_IN = 8'h00;
        #1;
        checks++; if (bus.TX_PKT_RDY_OUT !== 8'h00) begin errors++; $display("FAIL single_rdy_off got=%h exp=00", bus.TX_PKT_RDY_OUT); end
        checks++; if (bus.TXDATA_OUT !== 32'hFB00_0203 || bus.TXCHARISK_OUT !== 4'b1000) begin errors++; $display("FAIL single_hdr got=%h/%b exp=fb000203/1000", bus.TXDATA_OUT, bus.TXCHARISK_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'h1122_3344 || bus.TXCHARISK_OUT !== 4'b0000) begin errors++; $display("FAIL single_w0 got=%h/%b exp=11223344/0000", bus.TXDATA_OUT, bus.TXCHARISK_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'h5566_7788 || bus.TXCHARISK_OUT !== 4'b0000) begin errors++; $display("FAIL single_w1 got=%h/%b exp=55667788/0000", bus.TXDATA_OUT, bus.TXCHARISK_OUT); end
        checks++; if (bus.FRAMES_SENT_OUT !== 32'd1) begin errors++; $display("FAIL single_frames got=%0d exp=1", bus.FRAMES_SENT_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000 || bus.TXCHARISK_OUT !== 4'b1000) begin errors++; $display("FAIL single_idle got=%h/%b exp=bc000000/1000", bus.TXDATA_OUT, bus.TXCHARISK_OUT); end
    endtask

    task automatic test_round_robin();
        int          ch;
        logic [7:0]  exp_rdy;
        do_reset();
        for (int c = 0; c < NCH; c++) bus.TX_PKT_DATA_IN[c*PB +: PB] = {32'hD000_0000 + 32'(c), 32'hE000_0000 + 32'(c)};
        bus.TX_PKT_VLD_IN = 8'hFF;
        for (int f = 0; f < 9; f++) begin
            ch      = f % NCH;
            exp_rdy = 8'd1 << ch;
            #1;
            if (f > 0) begin
                checks++; if (bus.TXDATA_OUT !== 32'hE000_0000 + 32'((f - 1) % NCH)) begin errors++; $display("FAIL rr_w1 frame=%0d got=%h", f - 1, bus.TXDATA_OUT); end
            end
            checks++; if (bus.TX_PKT_RDY_OUT !== exp_rdy) begin errors++; $display("FAIL rr_grant frame=%0d got=%h exp=%h", f, bus.TX_PKT_RDY_OUT, exp_rdy); end
            tick();
            checks++; if (bus.TXDATA_OUT !== {8'hFB, 8'h00, 8'h02, 8'(ch)}) begin errors++; $display("FAIL rr_hdr frame=%0d got=%h", f, bus.TXDATA_OUT); end
            tick();
            checks++; if (bus.TXDATA_OUT !== 32'hD000_0000 + 32'(ch)) begin errors++; $display("FAIL rr_w0 frame=%0d got=%h", f, bus.TXDATA_OUT); end
            tick();
        end
        bus.TX_PKT_VLD_IN = 8'h00;
    endtask

    task automatic test_credit_exhaust();
        int n;
        do_reset();
        bus.TX_PKT_DATA_IN[PB-1:0] = 64'h0123_4567_89AB_CDEF;
        bus.TX_PKT_VLD_IN = 8'h01;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1; if (bus.TX_PKT_RDY_OUT[0]) n++;
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL exhaust_frames got=%0d exp=8", n); end
        #1;
        checks++; if (bus.TX_PKT_RDY_OUT !== 8'h00 || bus.TXDATA_OUT !== 32'hBC00_0000) begin errors++; $display("FAIL exhaust_idle rdy=%h data=%h exp 00/bc000000", bus.TX_PKT_RDY_OUT, bus.TXDATA_OUT); end
        bus.CREDIT_RET_VLD_IN  = 1'b1;
        bus.CREDIT_RET_CHAN_IN = 3'd0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1; if (bus.TX_PKT_RDY_OUT[0]) n++;
            tick();
            bus.CREDIT_RET_VLD_IN = 1'b0;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL refill_frames got=%0d exp=1", n); end
        checks++; if (bus.FRAMES_SENT_OUT !== 32'd9) begin errors++; $display("FAIL refill_count got=%0d exp=9", bus.FRAMES_SENT_OUT); end
        bus.TX_PKT_VLD_IN = 8'h00;
    endtask

    task automatic test_stall_and_err();
        do_reset();
        bus.TX_PKT_DATA_IN[5*PB +: PB] = 64'hCAFE_BABE_0BAD_F00D;
        bus.TX_PKT_VLD_IN = 8'h20;
        #1;
        checks++; if (bus.TX_PKT_RDY_OUT !== 8'h20) begin errors++; $display("FAIL stall_rdy got=%h exp=20", bus.TX_PKT_RDY_OUT); end
        tick();
        bus.TX_PKT_VLD_IN = 8'h00;
        tick();
        bus.TXRDY_IN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.TXDATA_OUT !== 32'hCAFE_BABE) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=cafebabe", i, bus.TXDATA_OUT); end
            tick();
        end
        bus.TXRDY_IN = 1'b1;
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'hCAFE_BABE) begin errors++; $display("FAIL stall_release got=%h exp=cafebabe", bus.TXDATA_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'h0BAD_F00D || bus.FRAMES_SENT_OUT !== 32'd1) begin errors++; $display("FAIL stall_w1 got=%h frames=%0d exp=0badf00d/1", bus.TXDATA_OUT, bus.FRAMES_SENT_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000) begin errors++; $display("FAIL stall_idle got=%h exp=bc000000", bus.TXDATA_OUT); end
        bus.CREDIT_RET_VLD_IN  = 1'b1;
        bus.CREDIT_RET_CHAN_IN = 3'd5;
        tick();
        bus.CREDIT_RET_VLD_IN  = 1'b0;
        #1;
        checks++; if (bus.CREDIT_ERR_OUT !== 1'b0) begin errors++; $display("FAIL err_refill got=%b exp=0", bus.CREDIT_ERR_OUT); end
        bus.CREDIT_RET_VLD_IN  = 1'b1;
        tick();
        bus.CREDIT_RET_VLD_IN  = 1'b0;
        #1;
        checks++; if (bus.CREDIT_ERR_OUT !== 1'b1) begin errors++; $display("FAIL err_overflow got=%b exp=1", bus.CREDIT_ERR_OUT); end
        tick(); tick(); tick();
        checks++; if (bus.CREDIT_ERR_OUT !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", bus.CREDIT_ERR_OUT); end
    endtask

    task automatic test_link_drop();
        int n;
        do_reset();
        bus.CREDIT_RET_VLD_IN  = 1'b1;
        bus.CREDIT_RET_CHAN_IN = 3'd7;
        tick();
        bus.CREDIT_RET_VLD_IN  = 1'b0;
        bus.TX_PKT_DATA_IN[2*PB +: PB] = 64'hA1A2_A3A4_B1B2_B3B4;
        bus.TX_PKT_VLD_IN = 8'h04;
        tick();
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'hFB00_0202) begin errors++; $display("FAIL link_hdr got=%h exp=fb000202", bus.TXDATA_OUT); end
        tick();
        bus.HANDSHAKE_COMPLETE_IN = 1'b0;
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'hA1A2_A3A4) begin errors++; $display("FAIL link_w0 got=%h exp=a1a2a3a4", bus.TXDATA_OUT); end
        tick();
        checks++; if (bus.TXDATA_OUT !== 32'hB1B2_B3B4 || bus.FRAMES_SENT_OUT !== 32'd1) begin errors++; $display("FAIL link_w1 got=%h frames=%0d exp=b1b2b3b4/1", bus.TXDATA_OUT, bus.FRAMES_SENT_OUT); end
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000 || bus.TX_PKT_RDY_OUT !== 8'h00) begin errors++; $display("FAIL link_down_idle data=%h rdy=%h exp bc000000/00", bus.TXDATA_OUT, bus.TX_PKT_RDY_OUT); end
            tick();
        end
        bus.HANDSHAKE_COMPLETE_IN = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1; if (bus.TX_PKT_RDY_OUT[2]) n++;
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL link_reload frames=%0d exp=8", n); end
        checks++; if (bus.CREDIT_ERR_OUT !== 1'b1) begin errors++; $display("FAIL link_err_kept got=%b exp=1", bus.CREDIT_ERR_OUT); end
        bus.TX_PKT_VLD_IN = 8'h00;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.TX_PKT_DATA_IN[PB +: PB] = 64'h5A5A_5A5A_A5A5_A5A5;
        bus.TX_PKT_VLD_IN = 8'h02;
        tick();
        bus.TX_PKT_VLD_IN = 8'h00;
        tick();
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'h5A5A_5A5A) begin errors++; $display("FAIL abort_pre got=%h exp=5a5a5a5a", bus.TXDATA_OUT); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.TXDATA_OUT !== 32'hBC00_0000 || bus.TXCHARISK_OUT !== 4'b1000 || bus.FRAMES_SENT_OUT !== 32'd0)
            begin errors++; $display("FAIL abort_idle got=%h/%b frames=%0d exp bc000000/1000/0", bus.TXDATA_OUT, bus.TXCHARISK_OUT, bus.FRAMES_SENT_OUT); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int         g;
        logic [7:0] exp_rdy;
        do_reset();
        m_word = 32'hBC00_0000; m_k = 4'b1000; m_rr = 0; m_err = 1'b0; m_frames = 0;
        m_q.delete();
        for (int c = 0; c < NCH; c++) m_cred[c] = CRED;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) bus.TX_PKT_DATA_IN[c*PB +: PB] = {$urandom, $urandom};
            bus.TX_PKT_VLD_IN      = 8'($urandom);
            bus.TXRDY_IN           = ($urandom_range(3) != 0);
            if ($urandom_range(39) == 0) bus.HANDSHAKE_COMPLETE_IN = ~bus.HANDSHAKE_COMPLETE_IN;
            bus.CREDIT_RET_VLD_IN  = ($urandom_range(5) == 0);
            bus.CREDIT_RET_CHAN_IN = 3'($urandom);
            #1;
            g = m_grant();
            exp_rdy = 8'h00;
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++; if (bus.TX_PKT_RDY_OUT !== exp_rdy) begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%h exp=%h", i, bus.TX_PKT_RDY_OUT, exp_rdy); end
            checks++; if (bus.TXDATA_OUT !== m_word || bus.TXCHARISK_OUT !== m_k) begin errors++; $display("FAIL rnd_word cyc=%0d got=%h/%b exp=%h/%b", i, bus.TXDATA_OUT, bus.TXCHARISK_OUT, m_word, m_k); end
            checks++; if (bus.CREDIT_ERR_OUT !== m_err || bus.FRAMES_SENT_OUT !== 32'(m_frames)) begin errors++; $display("FAIL rnd_status cyc=%0d err=%b frames=%0d exp=%b/%0d", i, bus.CREDIT_ERR_OUT, bus.FRAMES_SENT_OUT, m_err, m_frames); end
            @(posedge clk);
            m_step(g);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_credit_exhaust();
        test_stall_and_err();
        test_link_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
